// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display.
// A shadow register holds one 4-bit display code and one decimal point per
// digit. Each code is decoded into active-low segments, including the
// temperature glyphs (dash, C, d, degree, F). A prescaler steps the digit
// index once per slot. The first GUARD_CYCLES of every slot keep all anodes
// off, which suppresses ghosting when the segment bus changes digits.
//
// Optional feature (compile-time macro SEG7_LEADING_ZERO_BLANK_EN):
//   When defined, leading zeros are shown as blanks. Digit 0 is never
//   suppressed, and the dp of a suppressed digit still lights.
//
// Parameters:
//   DIGITS        number of multiplexed digits (1..8)
//   SLOT_CYCLES   clock cycles per digit slot (>= 4)
//   GUARD_CYCLES  all-anodes-off cycles at the start of each slot
//                 (1 <= GUARD_CYCLES < SLOT_CYCLES)
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   code_in     display codes, digit i = code_in[4i+3:4i], digit 0 rightmost
//   dp_in       decimal point request per digit, 1 = lit
//   load        capture code_in/dp_in into the shadow register
//   blank       1 = all anodes off; the scan keeps running
//   seg         active-low segments {a,b,c,d,e,f,g,dp}
//   an          active-low anode enables, an[i] drives digit i
//   slot_start  registered one-cycle pulse on the first cycle of every slot
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned SLOT_CYCLES  = 50000,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   code_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  slot_start
);

    localparam int unsigned CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD  = CNT_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [3:0]       CODE_ZERO  = 4'd0;
    localparam logic [3:0]       CODE_BLANK = 4'd10;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [3:0]        r_code [DIGITS];
    logic [DIGITS-1:0] r_dp;

    logic [7:0]        r_seg;
    logic [DIGITS-1:0] r_an;
    logic              r_slot_start;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    logic [3:0]        w_disp_code [DIGITS];
    logic [3:0]        w_sel_code;
    logic              w_sel_dp;
    logic              w_slot_last;
    logic              w_lit;
    logic [7:0]        w_seg;
    logic [DIGITS-1:0] w_an;

    // Active-low segment pattern {a,b,c,d,e,f,g} for a display code.
    function automatic logic [6:0] decode_code(input logic [3:0] code);
        logic [6:0] pat;
        pat = 7'b1111111;
        case (code)
            4'd0:    pat = 7'b0000001;
            4'd1:    pat = 7'b1001111;
            4'd2:    pat = 7'b0010010;
            4'd3:    pat = 7'b0000110;
            4'd4:    pat = 7'b1001100;
            4'd5:    pat = 7'b0100100;
            4'd6:    pat = 7'b0100000;
            4'd7:    pat = 7'b0001111;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0000100;
            4'd10:   pat = 7'b1111111;  // blank
            4'd11:   pat = 7'b1111110;  // dash
            4'd12:   pat = 7'b0110001;  // C
            4'd13:   pat = 7'b1000010;  // d
            4'd14:   pat = 7'b0011100;  // degree
            4'd15:   pat = 7'b0111000;  // F
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    // -------------------------------------------------------------------------
    // Prescaler and digit index
    // -------------------------------------------------------------------------
    assign w_slot_last = (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_last) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Shadow register; reset leaves every digit blank with dp off
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                r_code[i] <= CODE_BLANK;
            end
            r_dp <= '0;
        end else if (load) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                r_code[i] <= code_in[4*i +: 4];
            end
            r_dp <= dp_in;
        end
    end

    // -------------------------------------------------------------------------
    // Displayed code per digit
    // -------------------------------------------------------------------------
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Walk from the most significant digit down; a zero is suppressed while
    // everything above it is still zero or blank. Digit 0 always shows.
    always_comb begin : lead_zero_blank
        logic w_above_empty;
        w_above_empty = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            w_disp_code[i] = r_code[i];
        end
        for (int i = int'(DIGITS) - 1; i > 0; i--) begin
            if (w_above_empty && (r_code[i] == CODE_ZERO)) begin
                w_disp_code[i] = CODE_BLANK;
            end
            w_above_empty = w_above_empty &&
                            ((r_code[i] == CODE_ZERO) || (r_code[i] == CODE_BLANK));
        end
    end
`else
    // Codes are displayed literally.
    always_comb begin : literal_codes
        for (int i = 0; i < int'(DIGITS); i++) begin
            w_disp_code[i] = r_code[i];
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Selected digit decode and anode pattern
    // -------------------------------------------------------------------------
    assign w_sel_code = w_disp_code[r_idx];
    assign w_sel_dp   = r_dp[r_idx];
    assign w_lit      = (r_cnt >= CNT_GUARD) && !blank;

    always_comb begin : seg_an_next
        w_seg = 8'hFF;
        w_an  = '1;
        w_seg = {decode_code(w_sel_code), ~w_sel_dp};
        if (w_lit) begin
            w_an[r_idx] = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Output registers: reflect cnt/idx/shadow of the previous cycle
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg        <= 8'hFF;
            r_an         <= '1;
            r_slot_start <= 1'b0;
        end else begin
            r_seg        <= w_seg;
            r_an         <= w_an;
            r_slot_start <= (r_cnt == '0);
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign slot_start = r_slot_start;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Self-checking bench for seg7_scan_driver with DIGITS=4, SLOT_CYCLES=8,
// GUARD_CYCLES=2. A small scan model predicts seg/an/slot_start for every
// clock; per-digit segment values come from hand-decoded vector tables.
// Expected outputs are queued when the stimulus is driven and compared after
// the clock edge that produces them.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int unsigned DIGITS       = 4;
    localparam int unsigned SLOT_CYCLES  = 8;
    localparam int unsigned GUARD_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] code_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        slot_start;

    seg7_scan_driver #(
        .DIGITS       (DIGITS),
        .SLOT_CYCLES  (SLOT_CYCLES),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .code_in    (code_in),
        .dp_in      (dp_in),
        .load       (load),
        .blank      (blank),
        .seg        (seg),
        .an         (an),
        .slot_start (slot_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]     code;
        logic [3:0]      dp;
        logic [3:0][7:0] exp;   // exp[i] = expected seg for digit i
    } vec_t;

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] an;
        logic       ss;
    } exp_t;

    exp_t q[$];

    int n_pass  = 0;
    int n_total = 0;

    // Scan model state
    int              m_cnt = 0;
    int              m_idx = 0;
    logic [3:0][7:0] m_disp = {4{8'hFF}};
    logic [3:0][7:0] ld_disp;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // One clock: predict, push, advance model, clock, pop and compare.
    task automatic cycle();
        exp_t e;
        exp_t got;
        if (rst) begin
            e.seg = 8'hFF;
            e.an  = 4'hF;
            e.ss  = 1'b0;
        end else begin
            e.seg = m_disp[m_idx];
            e.an  = (!blank && m_cnt >= int'(GUARD_CYCLES)) ? ~(4'(1) << m_idx) : 4'hF;
            e.ss  = (m_cnt == 0);
        end
        q.push_back(e);
        if (rst) begin
            m_cnt  = 0;
            m_idx  = 0;
            m_disp = {4{8'hFF}};
        end else begin
            if (m_cnt == int'(SLOT_CYCLES) - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % int'(DIGITS);
            end else begin
                m_cnt++;
            end
            if (load) m_disp = ld_disp;
        end
        @(posedge clk);
        #1;
        got = q.pop_front();
        chk("seg", seg, got.seg);
        chk("an", {4'h0, an}, {4'h0, got.an});
        chk("slot_start", {7'h0, slot_start}, {7'h0, got.ss});
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    // Advance until the model sits at (idx, cnt) before the next edge.
    task automatic run_until(input int idx, input int cnt);
        int n;
        n = 0;
        while (!(m_idx == idx && m_cnt == cnt) && n < 100) begin
            cycle();
            n++;
        end
        n_total++;
        if (m_idx == idx && m_cnt == cnt) n_pass++;
        else $display("FAIL run_until: timeout waiting for idx=%0d cnt=%0d", idx, cnt);
    endtask

    task automatic do_load(input logic [15:0] c, input logic [3:0] d, input logic [3:0][7:0] ex);
        code_in = c;
        dp_in   = d;
        ld_disp = ex;
        load    = 1'b1;
        cycle();
        load    = 1'b0;
    endtask

    vec_t vecs[7];

    initial begin
        // Expected patterns decoded by hand: {seg[7:1], ~dp}
        vecs[0] = '{16'h1234, 4'b0100, {8'b10011111, 8'b00100100, 8'b00001101, 8'b10011001}};
        vecs[1] = '{16'hFEDC, 4'b0000, {8'b01110001, 8'b00111001, 8'b10000101, 8'b01100011}};
        vecs[2] = '{16'hBA98, 4'b0000, {8'b11111101, 8'hFF,       8'b00001001, 8'b00000001}};
        vecs[3] = '{16'h5678, 4'b0000, {8'b01001001, 8'b01000001, 8'b00011111, 8'b00000001}};
        vecs[4] = '{16'hAAAA, 4'b1010, {8'hFE,       8'hFF,       8'hFE,       8'hFF}};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        vecs[5] = '{16'h0070, 4'b0000, {8'hFF,       8'hFF,       8'b00011111, 8'b00000011}};
        vecs[6] = '{16'h0105, 4'b1000, {8'hFE,       8'b10011111, 8'b00000011, 8'b01001001}};
`else
        vecs[5] = '{16'h0070, 4'b0000, {8'b00000011, 8'b00000011, 8'b00011111, 8'b00000011}};
        vecs[6] = '{16'h0105, 4'b1000, {8'b00000010, 8'b10011111, 8'b00000011, 8'b01001001}};
`endif

        rst     = 1'b1;
        load    = 1'b0;
        blank   = 1'b0;
        code_in = 16'h0;
        dp_in   = 4'h0;
        ld_disp = {4{8'hFF}};

        // Reset held for 3 cycles
        run(3);
        rst = 1'b0;
        cycle();
        chk("post_reset_slot_start", {7'h0, slot_start}, 8'h01);
        chk("post_reset_an_guard", {4'h0, an}, 8'h0F);

        // Table-driven loads, each observed over more than one full scan
        for (int v = 0; v < 7; v++) begin
            do_load(vecs[v].code, vecs[v].dp, vecs[v].exp);
            run(40);
        end

        // Mid-slot load at cnt=4 of slot 0
        run_until(0, 4);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        do_load(16'h0005, 4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'b01001001});
`else
        do_load(16'h0005, 4'b0000, {8'b00000011, 8'b00000011, 8'b00000011, 8'b01001001});
`endif
        cycle();
        chk("mid_slot_load_seg", seg, 8'b01001001);

        // Blank for 3 cycles inside a lit slot
        run_until(0, 2);
        blank = 1'b1;
        run(3);
        chk("blank_an", {4'h0, an}, 8'h0F);
        blank = 1'b0;
        cycle();
        chk("unblank_an", {4'h0, an}, 8'h0E);
        run(10);

        // Reset mid-scan
        run_until(2, 5);
        rst = 1'b1;
        cycle();
        chk("mid_reset_seg", seg, 8'hFF);
        chk("mid_reset_an", {4'h0, an}, 8'h0F);
        rst = 1'b0;
        cycle();
        chk("restart_slot_start", {7'h0, slot_start}, 8'h01);
        run(40);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
